text_buffer_writer: RTL and testbench
=====================================

// Module: text_buffer_writer
// PURPOSE
//  Writer side of the character text buffer that the pixel encoder reads (row/col -> char code).
//  Accepts a byte stream (keyboard/UART), handles printable chars, backspace and newline,
//  and tracks a cursor. Issues single-cell writes into the ROWS x COLS char RAM.
//  Blanks the whole screen after reset or on request, and blanks each newly entered row.
// PARAMETERS
//  ROWS   7      text rows; must match the display grid (7 x 32-px rows)
//  COLS   20     text columns; must match the display grid (20 x 16-px cols)
//  BLANK  8'h20  code written to cleared cells
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  reset       in   1  synchronous, active-high
//  char_in     in   8  input byte
//  char_valid  in   1  char_in valid
//  char_ready  out  1  block can accept; transfer when char_valid & char_ready
//  clear_req   in   1  single-cycle pulse: blank the whole screen, cursor -> (0,0)
//  we          out  1  char RAM write enable, one cell per cycle
//  wr_row      out  4  write row   (same encoding as pixel encoder rin)
//  wr_col      out  6  write column (same encoding as pixel encoder cin)
//  wr_data     out  8  char code to write
//  cur_row     out  4  cursor row
//  cur_col     out  6  cursor column
//  busy        out  1  high in CLEAR_ALL / CLEAR_ROW
// BEHAVIOUR
//  Reset: we=0, wr_row=0, wr_col=0, wr_data=BLANK, cur=(0,0), char_ready=0, busy=1, state=CLEAR_ALL, sweep=(0,0).
//  All outputs registered. Write latency: accept at edge N -> we=1 for exactly cycle N+1.
//  States: CLEAR_ALL, IDLE, CLEAR_ROW. char_ready=1 only in IDLE with no clear_req that cycle.
//  CLEAR_ALL: ROWS*COLS consecutive writes of BLANK, row-major (0,0)..(6,19). First write in the
//   first cycle after reset deasserts; 140 cycles total. Then IDLE with char_ready=1.
//  IDLE accepted byte:
//   0x20..0x7E: write byte at cursor; cursor col+1. If col was COLS-1: col=0, row=(row+1)%ROWS,
//    then CLEAR_ROW on the new row.
//   0x08 BS: col>0 -> col-1, write BLANK there. col=0,row>0 -> (row-1,COLS-1), write BLANK.
//    (0,0) -> no write, no cursor change.
//   0x0D or 0x0A: col=0, row=(row+1)%ROWS, CLEAR_ROW on the new row. Row ROWS-1 wraps to 0 (no scroll).
//   Any other code: consumed, no write, no cursor change.
//  CLEAR_ROW: COLS consecutive writes of BLANK to the cursor row, col 0..COLS-1. Cursor already
//   at (row,0). Returns to IDLE; char_ready rises the cycle after the last write.
//  clear_req: honoured in any state, overrides a same-cycle char handshake (char_ready forced 0).
//   Aborts any sweep; cursor=(0,0); restarts CLEAR_ALL from (0,0).
//  Reset mid-sweep: full reset state; the sweep restarts from (0,0) after release.
//  Counters: row compared against ROWS-1, col against COLS-1. wr_row/wr_col never exceed 6/19.
//  char_in is sampled only on a handshake. Holding char_valid high yields one char per
//   accepted cycle (back-to-back printables at 1/cycle outside wrap points).
// STRUCTURE
//  Shared package text_pkg: ROWS, COLS, ROW_W=4, COL_W=6, CHAR_BLANK=8'h20, CHAR_BS=8'h08,
//   CHAR_CR=8'h0D, CHAR_LF=8'h0A, PRINT_MIN=8'h20, PRINT_MAX=8'h7E, state encodings.
//   The pixel encoder uses the same ROWS/COLS constants.
//  Sub-module cell_sweeper: row/col sweep counter with start, single_row, row_sel, done.
//   Used for both CLEAR_ALL and CLEAR_ROW. Top holds the FSM, cursor and output registers.
// TESTING
//  1 Release reset -> exactly 140 we pulses, BLANK, (0,0)..(6,19) in order; then char_ready=1, cur=(0,0).
//  2 Send 'A'(0x41),'B' back-to-back -> writes (0,0)=41, (0,1)=42 on consecutive cycles; cur=(0,2).
//  3 Send 20 printables on row 0 -> 20th written at (0,19); cur=(1,0); 20 BLANK writes to row 1,
//    busy=1 and char_ready=0 throughout.
//  4 At (6,5) send 0x0D -> cur=(0,0); row 0 cleared (20 writes); next 'Z' lands at (0,0).
//  5 BS at (2,0) -> BLANK written at (1,19), cur=(1,19). BS at (0,0) -> no we, cur unchanged.
//    Byte 0x07 -> consumed, no we.
//  6 clear_req mid CLEAR_ROW with char_valid high -> no handshake that cycle; cur=(0,0); full
//    140-write sweep from (0,0). Reset asserted mid-sweep -> same sequence after release.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants, FSM encoding and write payload for the character text buffer.
// The pixel encoder uses the same ROWS/COLS so both sides agree on the grid.
package text_pkg;

    localparam int unsigned ROWS  = 7;
    localparam int unsigned COLS  = 20;
    localparam int unsigned ROW_W = 4;
    localparam int unsigned COL_W = 6;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    localparam logic [7:0] CHAR_BLANK = 8'h20;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] PRINT_MIN  = 8'h20;
    localparam logic [7:0] PRINT_MAX  = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLEAR_ALL = 2'd0,
        ST_IDLE      = 2'd1,
        ST_CLEAR_ROW = 2'd2
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [7:0]       data;
    } wr_cell_t;

    function automatic logic is_print(input logic [7:0] c);
        return (c >= PRINT_MIN) && (c <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/text_buffer_writer_if.sv
// Byte-stream input, char RAM write port and cursor/status of the text buffer writer.
interface text_buffer_writer_if;
    import text_pkg::*;

    logic [7:0]       char_in;
    logic             char_valid;
    logic             char_ready;
    logic             clear_req;
    logic             we;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic [7:0]       wr_data;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             busy;

    modport master (
        output char_in, char_valid, clear_req,
        input  char_ready, we, wr_row, wr_col, wr_data, cur_row, cur_col, busy
    );

    modport slave (
        input  char_in, char_valid, clear_req,
        output char_ready, we, wr_row, wr_col, wr_data, cur_row, cur_col, busy
    );

endinterface

// File: rtl/cell_sweeper.sv
// Row-major cell counter for blanking sweeps: whole screen from (0,0), or one row.
// o_done_c flags the last cell of the current sweep.
module cell_sweeper
    import text_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_single_row,
    input  logic [ROW_W-1:0] i_row_sel,
    input  logic             i_step,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_done_c
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_single;

    // Holds at the last cell so the position never leaves the grid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row    <= '0;
            r_col    <= '0;
            r_single <= 1'b0;
        end else if (i_start) begin
            r_row    <= i_row_sel;
            r_col    <= '0;
            r_single <= i_single_row;
        end else if (i_step && !o_done_c) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_done_c = (r_col == COL_LAST) && (r_single || (r_row == ROW_LAST));
    assign o_row    = r_row;
    assign o_col    = r_col;

endmodule

// File: rtl/text_buffer_writer.sv
// Writer side of the char text buffer: consumes a byte stream, tracks the cursor and
// issues one-cell writes, blanking the screen after reset/clear and each new row.
module text_buffer_writer
    import text_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    text_buffer_writer_if.slave  io_bus
);

    state_t           r_state, w_state_next;
    logic [ROW_W-1:0] r_cur_row, w_cur_row_next;
    logic [COL_W-1:0] r_cur_col, w_cur_col_next;
    wr_cell_t         r_wr, w_wr_next;
    logic             r_we, w_we_next;
    logic             r_ready, w_ready_next;
    logic             r_busy, w_busy_next;

    logic             w_accept;
    logic             w_newline;
    logic [ROW_W-1:0] w_row_inc;
    logic [COL_W-1:0] w_col_dec;
    logic             w_sw_start, w_sw_single, w_sw_step, w_sw_done;
    logic [ROW_W-1:0] w_sw_row_sel, w_sw_row;
    logic [COL_W-1:0] w_sw_col;

    cell_sweeper u_sweeper (
        .clk          (clk),
        .reset        (reset),
        .i_start      (w_sw_start),
        .i_single_row (w_sw_single),
        .i_row_sel    (w_sw_row_sel),
        .i_step       (w_sw_step),
        .o_row        (w_sw_row),
        .o_col        (w_sw_col),
        .o_done_c     (w_sw_done)
    );

    // A clear request wins over a same-cycle byte handshake.
    assign w_accept  = io_bus.char_valid & r_ready & ~io_bus.clear_req;
    assign w_row_inc = (r_cur_row == ROW_LAST) ? '0 : r_cur_row + ROW_W'(1);
    assign w_col_dec = r_cur_col - COL_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR_ALL;
            r_cur_row <= '0;
            r_cur_col <= '0;
            r_wr      <= {ROW_W'(0), COL_W'(0), CHAR_BLANK};
            r_we      <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cur_row <= w_cur_row_next;
            r_cur_col <= w_cur_col_next;
            r_wr      <= w_wr_next;
            r_we      <= w_we_next;
            r_ready   <= w_ready_next;
            r_busy    <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cur_row_next = r_cur_row;
        w_cur_col_next = r_cur_col;
        w_wr_next      = r_wr;
        w_we_next      = 1'b0;
        w_newline      = 1'b0;
        w_sw_start     = 1'b0;
        w_sw_single    = 1'b0;
        w_sw_row_sel   = '0;
        w_sw_step      = 1'b0;

        if (io_bus.clear_req) begin
            w_state_next   = ST_CLEAR_ALL;
            w_cur_row_next = '0;
            w_cur_col_next = '0;
            w_sw_start     = 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR_ALL, ST_CLEAR_ROW: begin
                    w_we_next = 1'b1;
                    w_wr_next = {w_sw_row, w_sw_col, CHAR_BLANK};
                    w_sw_step = 1'b1;
                    if (w_sw_done) w_state_next = ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        if (is_print(io_bus.char_in)) begin
                            w_we_next = 1'b1;
                            w_wr_next = {r_cur_row, r_cur_col, io_bus.char_in};
                            if (r_cur_col == COL_LAST) w_newline = 1'b1;
                            else w_cur_col_next = r_cur_col + COL_W'(1);
                        end else if (io_bus.char_in == CHAR_BS) begin
                            if (r_cur_col != '0) begin
                                w_cur_col_next = w_col_dec;
                                w_we_next      = 1'b1;
                                w_wr_next      = {r_cur_row, w_col_dec, CHAR_BLANK};
                            end else if (r_cur_row != '0) begin
                                w_cur_row_next = r_cur_row - ROW_W'(1);
                                w_cur_col_next = COL_LAST;
                                w_we_next      = 1'b1;
                                w_wr_next      = {r_cur_row - ROW_W'(1), COL_LAST, CHAR_BLANK};
                            end
                        end else if ((io_bus.char_in == CHAR_CR) || (io_bus.char_in == CHAR_LF)) begin
                            w_newline = 1'b1;
                        end
                    end
                end
                default: w_state_next = ST_CLEAR_ALL;
            endcase

            // New row (wrap or CR/LF): cursor to column 0, then blank that row.
            if (w_newline) begin
                w_state_next   = ST_CLEAR_ROW;
                w_cur_row_next = w_row_inc;
                w_cur_col_next = '0;
                w_sw_start     = 1'b1;
                w_sw_single    = 1'b1;
                w_sw_row_sel   = w_row_inc;
            end
        end

        // Ready only after a full IDLE cycle; busy covers the last sweep write.
        w_ready_next = (r_state == ST_IDLE) && (w_state_next == ST_IDLE);
        w_busy_next  = (r_state != ST_IDLE) || (w_state_next != ST_IDLE);
    end

    assign io_bus.char_ready = r_ready & ~io_bus.clear_req;
    assign io_bus.we         = r_we;
    assign io_bus.wr_row     = r_wr.row;
    assign io_bus.wr_col     = r_wr.col;
    assign io_bus.wr_data    = r_wr.data;
    assign io_bus.cur_row    = r_cur_row;
    assign io_bus.cur_col    = r_cur_col;
    assign io_bus.busy       = r_busy;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Bench for text_buffer_writer: reset/clear sweeps, a table of edit bytes, wrap and
// abort sequences, then random traffic against a queue-of-writes screen model.
module tb_text_buffer_writer;
    import text_pkg::*;

    logic clk;
    logic reset;

    text_buffer_writer_if bus_if ();

    text_buffer_writer dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
    } cell_t;

    typedef struct {
        int ch;
        int we;
        int row;
        int col;
        int data;
        int cur_row;
        int cur_col;
        int n_sweep;
    } vec_t;

    cell_t expq[$];
    int    m_row;
    int    m_col;
    int    checks;
    int    errors;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pos(input int r, input int c);
        return r * 256 + c;
    endfunction

    function automatic int cell_code(input int r, input int c, input int d);
        return r * 65536 + c * 256 + d;
    endfunction

    function automatic int dut_cell();
        return cell_code(int'(bus_if.wr_row), int'(bus_if.wr_col), int'(bus_if.wr_data));
    endfunction

    function automatic int dut_cur();
        return pos(int'(bus_if.cur_row), int'(bus_if.cur_col));
    endfunction

    // Screen model: list of writes the DUT still owes, plus the cursor.
    task automatic m_push(input int r, input int c, input int d);
        cell_t e;
        e.row = r;
        e.col = c;
        e.data = d;
        expq.push_back(e);
    endtask

    task automatic m_full_clear();
        expq.delete();
        m_row = 0;
        m_col = 0;
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++) m_push(r, c, 32);
    endtask

    task automatic m_newline();
        m_row = (m_row + 1) % int'(ROWS);
        m_col = 0;
        for (int c = 0; c < int'(COLS); c++) m_push(m_row, c, 32);
    endtask

    task automatic m_accept(input int ch);
        if (ch >= 32 && ch <= 126) begin
            m_push(m_row, m_col, ch);
            if (m_col == int'(COLS) - 1) m_newline();
            else m_col++;
        end else if (ch == 8) begin
            if (m_col > 0) begin
                m_col--;
                m_push(m_row, m_col, 32);
            end else if (m_row > 0) begin
                m_row--;
                m_col = int'(COLS) - 1;
                m_push(m_row, m_col, 32);
            end
        end else if (ch == 13 || ch == 10) begin
            m_newline();
        end
    endtask

    // One clock: drive at negedge, decide handshake, advance, check any write.
    task automatic step(input logic v, input logic [7:0] ch, input logic clr,
                        input logic rst, output logic acc);
        cell_t e;
        bus_if.char_valid = v;
        bus_if.char_in    = ch;
        bus_if.clear_req  = clr;
        reset             = rst;
        #1;
        acc = v && bus_if.char_ready && !rst;
        if (bus_if.char_ready && !rst) check("cursor_idle", dut_cur(), pos(m_row, m_col));
        if (rst || clr) m_full_clear();
        else if (acc) m_accept(int'(ch));
        @(posedge clk);
        @(negedge clk);
        if (bus_if.we) begin
            if (expq.size() == 0) begin
                check("spurious_we", dut_cell(), -1);
            end else begin
                e = expq.pop_front();
                check("write_cell", dut_cell(), cell_code(e.row, e.col, e.data));
            end
        end
    endtask

    task automatic send(input logic [7:0] ch, output int cyc);
        logic acc;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 300) begin
            step(1'b1, ch, 1'b0, 1'b0, acc);
            cyc++;
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic wait_ready(output int nwe, output int nbusy_low);
        logic acc;
        nwe = 0;
        nbusy_low = 0;
        for (int i = 0; i < 300 && !bus_if.char_ready; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, acc);
            if (!bus_if.char_ready) begin
                if (bus_if.we) nwe++;
                if (!bus_if.busy) nbusy_low++;
            end
        end
        if (!bus_if.char_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic do_reset(input string tag);
        logic acc;
        int   nwe, nbl;
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check({tag, "_rst_we"}, int'(bus_if.we), 0);
        check({tag, "_rst_wr"}, dut_cell(), cell_code(0, 0, 32));
        check({tag, "_rst_cur"}, dut_cur(), 0);
        check({tag, "_rst_ready"}, int'(bus_if.char_ready), 0);
        check({tag, "_rst_busy"}, int'(bus_if.busy), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        check({tag, "_first_we"}, int'(bus_if.we), 1);
        check({tag, "_first_cell"}, dut_cell(), cell_code(0, 0, 32));
        wait_ready(nwe, nbl);
        check({tag, "_sweep_count"}, nwe + 1, 140);
        check({tag, "_sweep_busy"}, nbl, 0);
        check({tag, "_idle_busy"}, int'(bus_if.busy), 0);
        check({tag, "_idle_cur"}, dut_cur(), 0);
    endtask

    vec_t vt[18];

    initial begin
        logic acc;
        int   cyc, nwe, nbl, ch, r;

        checks = 0;
        errors = 0;
        m_row  = 0;
        m_col  = 0;
        bus_if.char_valid = 1'b0;
        bus_if.char_in    = 8'h00;
        bus_if.clear_req  = 1'b0;
        reset = 1'b1;

        //          ch     we row col data   cur    sweep
        vt[0]  = '{8'h43, 1, 0,  2, 8'h43, 0,  3, 0};
        vt[1]  = '{8'h08, 1, 0,  2, 8'h20, 0,  2, 0};
        vt[2]  = '{8'h07, 0, 0,  0, 0,     0,  2, 0};
        vt[3]  = '{8'h0D, 0, 0,  0, 0,     1,  0, 20};
        vt[4]  = '{8'h08, 1, 0, 19, 8'h20, 0, 19, 0};
        vt[5]  = '{8'h7E, 1, 0, 19, 8'h7E, 1,  0, 20};
        vt[6]  = '{8'h0A, 0, 0,  0, 0,     2,  0, 20};
        vt[7]  = '{8'h08, 1, 1, 19, 8'h20, 1, 19, 0};
        vt[8]  = '{8'h0A, 0, 0,  0, 0,     2,  0, 20};
        vt[9]  = '{8'h0A, 0, 0,  0, 0,     3,  0, 20};
        vt[10] = '{8'h0A, 0, 0,  0, 0,     4,  0, 20};
        vt[11] = '{8'h0A, 0, 0,  0, 0,     5,  0, 20};
        vt[12] = '{8'h0A, 0, 0,  0, 0,     6,  0, 20};
        vt[13] = '{8'h20, 1, 6,  0, 8'h20, 6,  1, 0};
        vt[14] = '{8'h7F, 0, 0,  0, 0,     6,  1, 0};
        vt[15] = '{8'h0D, 0, 0,  0, 0,     0,  0, 20};
        vt[16] = '{8'h08, 0, 0,  0, 0,     0,  0, 0};
        vt[17] = '{8'h5A, 1, 0,  0, 8'h5A, 0,  1, 0};

        do_reset("por");

        // Back-to-back printables, one write per cycle.
        send(8'h41, cyc);
        check("ab_cyc_a", cyc, 1);
        check("ab_we_a", int'(bus_if.we), 1);
        check("ab_cell_a", dut_cell(), cell_code(0, 0, 8'h41));
        send(8'h42, cyc);
        check("ab_cyc_b", cyc, 1);
        check("ab_cell_b", dut_cell(), cell_code(0, 1, 8'h42));
        check("ab_cur", dut_cur(), pos(0, 2));

        for (int i = 0; i < 18; i++) begin
            send(8'(vt[i].ch), cyc);
            check($sformatf("vec%0d_we", i), int'(bus_if.we), vt[i].we);
            if (vt[i].we != 0)
                check($sformatf("vec%0d_cell", i), dut_cell(),
                      cell_code(vt[i].row, vt[i].col, vt[i].data));
            check($sformatf("vec%0d_cur", i), dut_cur(), pos(vt[i].cur_row, vt[i].cur_col));
            wait_ready(nwe, nbl);
            check($sformatf("vec%0d_sweep", i), nwe, vt[i].n_sweep);
            check($sformatf("vec%0d_busy", i), nbl, 0);
        end

        // Fill row 1: 20th char lands at (1,19), then row 2 is blanked.
        send(8'h0D, cyc);
        wait_ready(nwe, nbl);
        for (int i = 0; i < 20; i++) send(8'(8'h41 + i), cyc);
        check("wrap_cell", dut_cell(), cell_code(1, 19, 8'h54));
        check("wrap_cur", dut_cur(), pos(2, 0));
        check("wrap_busy", int'(bus_if.busy), 1);
        check("wrap_ready", int'(bus_if.char_ready), 0);
        wait_ready(nwe, nbl);
        check("wrap_sweep", nwe, 20);
        check("wrap_sweep_busy", nbl, 0);

        // Clear in IDLE with a byte offered: no handshake, full sweep.
        step(1'b1, 8'h41, 1'b1, 1'b0, acc);
        check("clr_idle_acc", int'(acc), 0);
        check("clr_idle_we", int'(bus_if.we), 0);
        check("clr_idle_cur", dut_cur(), 0);
        wait_ready(nwe, nbl);
        check("clr_idle_sweep", nwe, 140);

        // Clear in the middle of a row sweep.
        send(8'h0A, cyc);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        step(1'b1, 8'h41, 1'b1, 1'b0, acc);
        check("clr_row_acc", int'(acc), 0);
        check("clr_row_we", int'(bus_if.we), 0);
        check("clr_row_cur", dut_cur(), 0);
        check("clr_row_busy", int'(bus_if.busy), 1);
        wait_ready(nwe, nbl);
        check("clr_row_sweep", nwe, 140);

        // Reset in the middle of a full sweep.
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        for (int i = 0; i < 50; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        do_reset("mid");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5) ch = int'($urandom_range(32, 126));
            else if (r == 6) ch = 8;
            else if (r == 7) ch = 13;
            else if (r == 8) ch = 10;
            else ch = int'($urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, 8'(ch), $urandom_range(0, 299) == 0, 1'b0, acc);
        end
        wait_ready(nwe, nbl);
        check("drain_queue", expq.size(), 0);
        check("drain_cur", dut_cur(), pos(m_row, m_col));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
